decade_tick_chain: RTL and testbench

- Fully synchronous successor to the ripple-clock audio prescaler.
- One master clock drives a parametrised cascade of divide-by-N stages. Each stage produces a one-cycle clock-enable tick and, optionally, a 50% square wave. No derived clocks are used.
- Adds run/freeze, phase realign, and one runtime-programmable channel with a load handshake.
- Sits between the board clock and the audio/timer logic, which consume the ticks as enables.

---
 rtl/decade_tick_pkg.sv | 24 ++
 rtl/tick_div_stage.sv | 51 +++++
 rtl/decade_tick_chain.sv | 119 +++++++++++
 tb/tb_decade_tick_chain.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/decade_tick_pkg.sv
// Shared constants, stage names and sizing helper for the decade tick cascade.
package decade_tick_pkg;

    localparam int DEF_PRE_DIV    = 40;
    localparam int DEF_STAGE_DIV  = 10;
    localparam int DEF_NUM_STAGES = 7;

    // Stage indices for the default 40 MHz build.
    typedef enum logic [2:0] {
        STG_1MHZ   = 3'd0,
        STG_100KHZ = 3'd1,
        STG_10KHZ  = 3'd2,
        STG_1KHZ   = 3'd3,
        STG_100HZ  = 3'd4,
        STG_10HZ   = 3'd5,
        STG_1HZ    = 3'd6
    } stage_e;

    // Width of a stage selector; a single-stage chain still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_div_stage.sv
// One modulo-N divide stage: advances on an input strobe, emits a carry strobe,
// a registered one-cycle tick and (with DECADE_TICK_SQ_EN) a registered 50% square wave.
module tick_div_stage #(
    parameter int N = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic carry,
    output logic tick,
    output logic sq
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;

    // Combinational so that every stage that wraps on the same clock carries together.
    assign carry = advance && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= carry;
            if (advance) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

`ifdef DECADE_TICK_SQ_EN
    localparam logic [CW-1:0] HALF = CW'(N / 2 - 1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            sq <= 1'b0;
        end else if (advance && (cnt == HALF || cnt == LAST)) begin
            sq <= ~sq;
        end
    end
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/decade_tick_chain.sv
// Fully synchronous prescaler cascade with one runtime-programmable channel.
// Square-wave outputs are generated only when DECADE_TICK_SQ_EN is defined.
module decade_tick_chain
    import decade_tick_pkg::*;
#(
    parameter int PRE_DIV    = DEF_PRE_DIV,
    parameter int STAGE_DIV  = DEF_STAGE_DIV,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int PROG_W     = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               clear,
    output logic [NUM_STAGES-1:0]              tick,
    output logic [NUM_STAGES-1:0]              sq,
    input  logic [PROG_W-1:0]                  prog_div,
    input  logic [sel_width(NUM_STAGES)-1:0]   prog_sel,
    input  logic                               prog_load,
    output logic                               prog_busy,
    output logic                               prog_tick,
    output logic                               prog_sq
);

    localparam int SEL_W = sel_width(NUM_STAGES);

    logic [NUM_STAGES-1:0] strobe;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            tick_div_stage #(.N(PRE_DIV)) u_stage (
                .clock   (clock),
                .reset   (reset),
                .clear   (clear),
                .advance (enable),
                .carry   (strobe[k]),
                .tick    (tick[k]),
                .sq      (sq[k])
            );
        end else begin : g_rest
            tick_div_stage #(.N(STAGE_DIV)) u_stage (
                .clock   (clock),
                .reset   (reset),
                .clear   (clear),
                .advance (strobe[k-1]),
                .carry   (strobe[k]),
                .tick    (tick[k]),
                .sq      (sq[k])
            );
        end
    end

    logic [PROG_W-1:0] div_q, pend_div, pc;
    logic [SEL_W-1:0]  sel_q, pend_sel;
    logic              src, stopped, wrap, commit, load_ok;

    // A selector beyond the last stage simply never strobes.
    assign src     = (int'(sel_q) < NUM_STAGES) ? strobe[sel_q] : 1'b0;
    assign stopped = (div_q == '0);
    assign wrap    = src && !stopped && (pc == div_q - 1'b1);
    assign commit  = prog_busy && (stopped || wrap);
    assign load_ok = prog_load && !prog_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q     <= '0;
            sel_q     <= '0;
            pend_div  <= '0;
            pend_sel  <= '0;
            prog_busy <= 1'b0;
            pc        <= '0;
            prog_tick <= 1'b0;
        end else begin
            if (load_ok) begin
                pend_div  <= prog_div;
                pend_sel  <= prog_sel;
                prog_busy <= 1'b1;
            end
            // Realign keeps the divisor and any pending request, only the phase restarts.
            if (clear) begin
                pc        <= '0;
                prog_tick <= 1'b0;
            end else begin
                prog_tick <= wrap;
                if (commit) begin
                    div_q     <= pend_div;
                    sel_q     <= pend_sel;
                    pc        <= '0;
                    prog_busy <= 1'b0;
                end else if (src && !stopped) begin
                    pc <= wrap ? '0 : pc + 1'b1;
                end
            end
        end
    end

`ifdef DECADE_TICK_SQ_EN
    logic [PROG_W-1:0] half;
    logic              sq_hit;

    // For D = 1 the half point does not exist and only the wrap toggles.
    assign half   = div_q >> 1;
    assign sq_hit = src && !stopped &&
                    ((half != '0 && pc == half - 1'b1) || pc == div_q - 1'b1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prog_sq <= 1'b0;
        end else if (commit) begin
            prog_sq <= 1'b0;
        end else if (sq_hit) begin
            prog_sq <= ~prog_sq;
        end
    end
`else
    assign prog_sq = 1'b0;
`endif

endmodule

// File: tb/tb_decade_tick_chain.sv
// Directed bench for decade_tick_chain with PRE_DIV=4, STAGE_DIV=10, NUM_STAGES=3.
// Square-wave expectations follow DECADE_TICK_SQ_EN.
module tb_decade_tick_chain;

    localparam int NS = 3;
`ifdef DECADE_TICK_SQ_EN
    localparam bit SQ_ON = 1'b1;
`else
    localparam bit SQ_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, enable, clear, prog_load;
    logic          prog_busy, prog_tick, prog_sq;
    logic [NS-1:0] tick, sq;
    logic [15:0]   prog_div;
    logic [1:0]    prog_sel;

    int            total = 0;
    int            bad   = 0;
    int            n     = 0;   // enabled clocks since the last reset/clear
    logic [NS-1:0] exp_tick, exp_sq;

    decade_tick_chain #(
        .PRE_DIV    (4),
        .STAGE_DIV  (10),
        .NUM_STAGES (NS),
        .PROG_W     (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .tick      (tick),
        .sq        (sq),
        .prog_div  (prog_div),
        .prog_sel  (prog_sel),
        .prog_load (prog_load),
        .prog_busy (prog_busy),
        .prog_tick (prog_tick),
        .prog_sq   (prog_sq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; cascade expectations: stage periods 4/40/400 clocks, sq high in the second half.
    task automatic step();
        logic r, c, e;
        r = reset;
        c = clear;
        e = enable;
        @(posedge clock);
        #1;
        if (r || c) begin
            n = 0;
            exp_tick = '0;
        end else if (e) begin
            n++;
            exp_tick = {n % 400 == 0, n % 40 == 0, n % 4 == 0};
        end else begin
            exp_tick = '0;
        end
        exp_sq = SQ_ON ? {(n % 400) >= 200, (n % 40) >= 20, (n % 4) >= 2} : '0;
        check($sformatf("tick n=%0d", n), 32'(tick), 32'(exp_tick));
        check($sformatf("sq n=%0d", n), 32'(sq), 32'(exp_sq));
    endtask

    task automatic check_prog(input logic et, input logic es, input logic eb);
        check($sformatf("prog_tick n=%0d", n), 32'(prog_tick), 32'(et));
        check($sformatf("prog_sq n=%0d", n), 32'(prog_sq), 32'(es & SQ_ON));
        check($sformatf("prog_busy n=%0d", n), 32'(prog_busy), 32'(eb));
    endtask

    initial begin
        int cnt0, cnt1, cnt2, first0, first1;

        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        prog_load = 1'b0; prog_div = '0; prog_sel = '0;
        repeat (3) step();
        check_prog(1'b0, 1'b0, 1'b0);

        // Free run: tick periods, first tick and three-way coincidence.
        reset = 1'b0; enable = 1'b1;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; first0 = -1;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (tick[0]) begin
                cnt0++;
                if (first0 < 0) first0 = i;
            end
            if (tick[1]) cnt1++;
            if (tick[2]) cnt2++;
            if (i == 400) check("coincide400", 32'(tick), 32'h7);
        end
        check("first_tick0", first0, 4);
        check("count_tick0", cnt0, 250);
        check("count_tick1", cnt1, 25);
        check("count_tick2", cnt2, 2);
        check_prog(1'b0, 1'b0, 1'b0);

        // Freeze for 13 clocks after cycle 101.
        reset = 1'b1; step(); reset = 1'b0;
        repeat (101) step();
        enable = 1'b0;
        repeat (13) step();
        enable = 1'b1;
        cnt1 = 0; first1 = -1;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (tick[1]) begin
                cnt1++;
                if (first1 < 0) first1 = 114 + k;
            end
        end
        check("freeze_tick1_cycle", first1, 133);
        check("freeze_tick1_count", cnt1, 1);

        // Clear pulse at cycle 57.
        reset = 1'b1; step(); reset = 1'b0;
        repeat (56) step();
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_tick", 32'(tick), 32'h0);
        check("clear_sq", 32'(sq), 32'h0);
        repeat (4) step();
        check("tick0_after_clear", 32'(tick[0]), 32'h1);

        // Load D=3 on stage 0 from the stopped state, then realign.
        prog_div = 16'd3; prog_sel = 2'd0; prog_load = 1'b1;
        step(); check_prog(1'b0, 1'b0, 1'b1);
        prog_load = 1'b0;
        step(); check_prog(1'b0, 1'b0, 1'b0);
        clear = 1'b1; step(); clear = 1'b0;
        check_prog(1'b0, 1'b0, 1'b0);
        repeat (30) begin
            step();
            check_prog(n % 12 == 0, (n % 12) >= 4, 1'b0);
        end

        // Mid-period load of D=5, a second load while busy is dropped.
        prog_div = 16'd5; prog_load = 1'b1;
        step(); check_prog(1'b0, (n % 12) >= 4, 1'b1);
        prog_load = 1'b0;
        step(); check_prog(1'b0, (n % 12) >= 4, 1'b1);
        prog_div = 16'd7; prog_load = 1'b1;
        step(); check_prog(1'b0, (n % 12) >= 4, 1'b1);
        prog_load = 1'b0;
        while (n < 100) begin
            step();
            if (n <= 36) check_prog(n % 12 == 0, (n % 12) >= 4, n < 36);
            else         check_prog((n - 36) % 20 == 0, ((n - 36) % 20) >= 8, 1'b0);
        end

        // D=0 stops the channel at the next boundary.
        prog_div = 16'd0; prog_load = 1'b1;
        step(); check_prog(1'b0, ((n - 36) % 20) >= 8, 1'b1);
        prog_load = 1'b0;
        while (n < 160) begin
            step();
            check_prog(n == 116, (n < 116) && (((n - 36) % 20) >= 8), n < 116);
        end

        // D=1 on stage 1 commits at once and follows tick[1].
        prog_div = 16'd1; prog_sel = 2'd1; prog_load = 1'b1;
        step(); check_prog(1'b0, 1'b0, 1'b1);
        prog_load = 1'b0;
        step(); check_prog(1'b0, 1'b0, 1'b0);
        while (n < 260) begin
            step();
            check_prog(n % 40 == 0, ((n / 40) % 2) == 1, 1'b0);
        end

        // Realign keeps the active divisor.
        clear = 1'b1; step(); clear = 1'b0;
        check_prog(1'b0, 1'b0, 1'b0);
        repeat (45) begin
            step();
            check_prog(n % 40 == 0, ((n / 40) % 2) == 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
